// File: rtl/seq_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_lock_ctrl
// Brief    : Code-entry lock controller. One sw bit is shifted in per key_p
//            press; a complete entry is compared with the stored code and
//            drives ok/err indications, with a timed lockout after MAX_FAIL
//            consecutive mismatches. A single shared down-counter times the
//            hold, lockout and entry-timeout intervals.
// Option   : SEQ_LOCK_PROG_EN - adds the PROG state so the code can be
//            re-programmed from the OK state via prog_key_p.
// Revision : 1.0 - initial release
// ============================================================================
module seq_lock_ctrl #(
  parameter int unsigned         CODE_LEN      = 4,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE  = 4'b1011,
  parameter int unsigned         MAX_FAIL      = 3,
  parameter int unsigned         HOLD_CYCLES   = 50_000_000,
  parameter int unsigned         LOCK_CYCLES   = 250_000_000,
  parameter int unsigned         ENTRY_TIMEOUT = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_p,
  input  logic       sw,
  input  logic       prog_key_p,
  output logic       led_ok,
  output logic       led_err,
  output logic       locked,
  output logic [2:0] state_code,
  output logic [3:0] bit_cnt,
  output logic [3:0] fail_cnt
);

  // State encodings
  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_enter = 3'd1;
  localparam logic [2:0] c_check = 3'd2;
  localparam logic [2:0] c_ok    = 3'd3;
  localparam logic [2:0] c_fail  = 3'd4;
  localparam logic [2:0] c_lock  = 3'd5;
`ifdef SEQ_LOCK_PROG_EN
  localparam logic [2:0] c_prog  = 3'd6;
`endif

  // Shared timer is sized for the longest of the three intervals
  localparam int unsigned c_max_hl    = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int unsigned c_timer_max = (c_max_hl > ENTRY_TIMEOUT) ? c_max_hl : ENTRY_TIMEOUT;
  localparam int unsigned c_timer_w   = $clog2(c_timer_max + 1);

  localparam logic [c_timer_w-1:0] c_t_hold = c_timer_w'(HOLD_CYCLES);
  localparam logic [c_timer_w-1:0] c_t_lock = c_timer_w'(LOCK_CYCLES);
  localparam logic [c_timer_w-1:0] c_t_to   = c_timer_w'(ENTRY_TIMEOUT);
  localparam logic [c_timer_w-1:0] c_t_one  = c_timer_w'(1);
  localparam logic [3:0]           c_len    = 4'(CODE_LEN);
  localparam logic [3:0]           c_maxf   = 4'(MAX_FAIL);

  logic [2:0]           state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [3:0]           fail_cnt_q, fail_cnt_d;
  logic [CODE_LEN-1:0]  entry_q, entry_d;
  logic [c_timer_w-1:0] timer_q, timer_d;
  logic                 led_ok_q, led_ok_d;
  logic                 led_err_q, led_err_d;
  logic                 locked_q, locked_d;

  logic [CODE_LEN-1:0]  w_entry_shift;
  logic [CODE_LEN-1:0]  w_code;
  logic                 w_expire;
  logic                 w_last_bit;
  logic                 w_match;
  logic                 w_lock_hit;

`ifdef SEQ_LOCK_PROG_EN
  logic [CODE_LEN-1:0]  shadow_q, shadow_d;
  logic [CODE_LEN-1:0]  code_q, code_d;
  logic [CODE_LEN-1:0]  w_shadow_shift;
  assign w_code = code_q;
`else
  logic                 w_unused_prog;
  assign w_unused_prog = prog_key_p;
  assign w_code        = DEFAULT_CODE;
`endif

  // A one-bit code has nothing to keep; wider codes shift left, new bit in LSB
  if (CODE_LEN == 1) begin : g_shift_one
    assign w_entry_shift = sw;
`ifdef SEQ_LOCK_PROG_EN
    assign w_shadow_shift = sw;
`endif
  end else begin : g_shift_wide
    assign w_entry_shift = {entry_q[CODE_LEN-2:0], sw};
`ifdef SEQ_LOCK_PROG_EN
    assign w_shadow_shift = {shadow_q[CODE_LEN-2:0], sw};
`endif
  end

  assign w_expire   = (timer_q == c_t_one);
  assign w_last_bit = (4'(bit_cnt_q + 4'd1) == c_len);
  assign w_match    = (entry_q == w_code);
  assign w_lock_hit = (4'(fail_cnt_q + 4'd1) == c_maxf);

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= c_idle;
      bit_cnt_q  <= '0;
      fail_cnt_q <= '0;
      entry_q    <= '0;
      timer_q    <= '0;
      led_ok_q   <= 1'b0;
      led_err_q  <= 1'b0;
      locked_q   <= 1'b0;
`ifdef SEQ_LOCK_PROG_EN
      shadow_q   <= '0;
      code_q     <= DEFAULT_CODE;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      entry_q    <= entry_d;
      timer_q    <= timer_d;
      led_ok_q   <= led_ok_d;
      led_err_q  <= led_err_d;
      locked_q   <= locked_d;
`ifdef SEQ_LOCK_PROG_EN
      shadow_q   <= shadow_d;
      code_q     <= code_d;
`endif
    end
  end

  // Next-state logic; a press on the timer's last cycle beats the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle: begin
        if (key_p) state_d = w_last_bit ? c_check : c_enter;
      end
      c_enter: begin
        if (key_p) begin
          if (w_last_bit) state_d = c_check;
        end else if (w_expire) begin
          state_d = c_idle;
        end
      end
      c_check: begin
        if (w_match)         state_d = c_ok;
        else if (w_lock_hit) state_d = c_lock;
        else                 state_d = c_fail;
      end
      c_ok: begin
`ifdef SEQ_LOCK_PROG_EN
        if (prog_key_p)    state_d = c_prog;
        else if (w_expire) state_d = c_idle;
`else
        if (w_expire) state_d = c_idle;
`endif
      end
      c_fail, c_lock: begin
        if (w_expire) state_d = c_idle;
      end
`ifdef SEQ_LOCK_PROG_EN
      c_prog: begin
        if (key_p) begin
          if (w_last_bit) state_d = c_idle;
        end else if (w_expire) begin
          state_d = c_idle;
        end
      end
`endif
      default: state_d = c_idle;
    endcase
  end

  // Entry, bit/fail counters and code storage
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    fail_cnt_d = fail_cnt_q;
    entry_d    = entry_q;
`ifdef SEQ_LOCK_PROG_EN
    shadow_d   = shadow_q;
    code_d     = code_q;
`endif
    case (state_q)
      c_idle, c_enter: begin
        if (key_p) begin
          entry_d   = w_entry_shift;
          bit_cnt_d = 4'(bit_cnt_q + 4'd1);
        end else if ((state_q == c_enter) && w_expire) begin
          entry_d   = '0;
          bit_cnt_d = '0;
        end
      end
      c_check: begin
        bit_cnt_d = '0;
        entry_d   = '0;
        if (w_match)         fail_cnt_d = '0;
        else if (w_lock_hit) fail_cnt_d = c_maxf;
        else                 fail_cnt_d = 4'(fail_cnt_q + 4'd1);
      end
      c_lock: begin
        if (w_expire) fail_cnt_d = '0;
      end
`ifdef SEQ_LOCK_PROG_EN
      c_ok: begin
        if (prog_key_p) begin
          bit_cnt_d = '0;
          shadow_d  = '0;
        end
      end
      c_prog: begin
        if (key_p) begin
          shadow_d = w_shadow_shift;
          if (w_last_bit) begin
            code_d    = w_shadow_shift;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = 4'(bit_cnt_q + 4'd1);
          end
        end else if (w_expire) begin
          bit_cnt_d = '0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Shared timer: reload on state entry or accepted press, else count down
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      case (state_d)
        c_enter:       timer_d = c_t_to;
`ifdef SEQ_LOCK_PROG_EN
        c_prog:        timer_d = c_t_to;
`endif
        c_ok, c_fail:  timer_d = c_t_hold;
        c_lock:        timer_d = c_t_lock;
        default:       timer_d = '0;
      endcase
`ifdef SEQ_LOCK_PROG_EN
    end else if (key_p && ((state_q == c_enter) || (state_q == c_prog))) begin
`else
    end else if (key_p && (state_q == c_enter)) begin
`endif
      timer_d = c_t_to;
    end else if (timer_q != '0) begin
      timer_d = timer_q - c_t_one;
    end
  end

  // Registered indications, valid on the first cycle of their state
  always_comb begin
    led_ok_d  = (state_d == c_ok);
    led_err_d = (state_d == c_fail) || (state_d == c_lock);
    locked_d  = (state_d == c_lock);
  end

  assign led_ok     = led_ok_q;
  assign led_err    = led_err_q;
  assign locked     = locked_q;
  assign state_code = state_q;
  assign bit_cnt    = bit_cnt_q;
  assign fail_cnt   = fail_cnt_q;

endmodule
`default_nettype wire
